cursor_engine: RTL and testbench

CURSOR_ENGINE -- requirements
Module: cursor_engine

---
 rtl/cursor_engine.sv | 258 +++++++++++++++++++++++++
 tb/tb_cursor_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cursor_engine.sv
// Cursor engine: tracks the terminal cursor, a small cursor save stack and
// issues scroll requests to the renderer with a req/ack handshake.
module cursor_engine #(
   parameter int LINES      = 24,
   parameter int COLUMNS    = 80,
   parameter int W          = 8,
   parameter int SAVE_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [3:0]   cmd_op,
   input  logic [W-1:0] cmd_n,
   input  logic [W-1:0] cmd_row,
   input  logic [W-1:0] cmd_col,
   input  logic         auto_wrap,
   input  logic         origin_mode,
   input  logic [W-1:0] scroll_top,
   input  logic [W-1:0] scroll_bottom,
   output logic [W-1:0] cur_row,
   output logic [W-1:0] cur_col,
   output logic         pending_wrap,
   output logic         scroll_req,
   output logic         scroll_dir,
   output logic [W-1:0] scroll_step,
   input  logic         scroll_ack,
   output logic         save_overflow
);

   localparam int SPW = $clog2(SAVE_DEPTH + 1);
   localparam int IW  = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;
   localparam int EW  = 2 * W + 1;

   typedef logic [W:0] cx_t;
   localparam cx_t ZERO     = cx_t'(0);
   localparam cx_t ONE      = cx_t'(1);
   localparam cx_t LAST_ROW = cx_t'(LINES - 1);
   localparam cx_t LAST_COL = cx_t'(COLUMNS - 1);

   localparam logic [3:0] OP_CUP     = 4'd1;
   localparam logic [3:0] OP_CUF     = 4'd2;
   localparam logic [3:0] OP_CUB     = 4'd3;
   localparam logic [3:0] OP_CUD     = 4'd4;
   localparam logic [3:0] OP_CUU     = 4'd5;
   localparam logic [3:0] OP_CR      = 4'd6;
   localparam logic [3:0] OP_LF      = 4'd7;
   localparam logic [3:0] OP_BS      = 4'd8;
   localparam logic [3:0] OP_PRINT   = 4'd9;
   localparam logic [3:0] OP_SAVE    = 4'd10;
   localparam logic [3:0] OP_RESTORE = 4'd11;
   localparam logic [3:0] OP_RI      = 4'd12;

   typedef enum logic {IDLE = 1'b0, SCROLL = 1'b1} state_t;

   state_t         state_r;
   logic [W-1:0]   cur_row_r, cur_col_r, sstep_r;
   logic           pw_r, sreq_r, sdir_r, ready_r, ovf_r;
   logic [SPW-1:0] sp_r;
   logic [EW-1:0]  stack_r [SAVE_DEPTH];

   cx_t            row_x_s, col_x_s, top_x_s, bot_x_s, n_x_s, crow_x_s, ccol_x_s;
   cx_t            lf_n_s, lf_sum_s, lf_row_s, lf_step_s, height_s, excess_s;
   cx_t            nrow_s, ncol_s, nstep_s, base_s, lim_s, sum_s, lo_s;
   logic           inside_s, lf_scroll_s, npw_s, nscroll_s, ndir_s, push_s, pop_s;
   logic           accept_s, full_s;
   logic [IW-1:0]  top_idx_s, push_idx_s;
   logic [EW-1:0]  top_entry_s, entry_s;

   assign cmd_ready     = ready_r;
   assign cur_row       = cur_row_r;
   assign cur_col       = cur_col_r;
   assign pending_wrap  = pw_r;
   assign scroll_req    = sreq_r;
   assign scroll_dir    = sdir_r;
   assign scroll_step   = sstep_r;
   assign save_overflow = ovf_r;

   assign accept_s    = cmd_valid && ready_r && (state_r == IDLE);
   assign full_s      = (sp_r == SPW'(SAVE_DEPTH));
   assign top_idx_s   = IW'(sp_r - SPW'(1));
   assign push_idx_s  = full_s ? IW'(SAVE_DEPTH - 1) : IW'(sp_r);
   assign top_entry_s = stack_r[top_idx_s];
   assign entry_s     = {cur_row_r, cur_col_r, pw_r};

   // Widened operands and the line-feed result shared by LF and wrapping PRINT
   always_comb begin
      row_x_s     = {1'b0, cur_row_r};
      col_x_s     = {1'b0, cur_col_r};
      top_x_s     = {1'b0, scroll_top};
      bot_x_s     = {1'b0, scroll_bottom};
      n_x_s       = (cmd_n == {W{1'b0}}) ? ONE : {1'b0, cmd_n};
      crow_x_s    = (cmd_row == {W{1'b0}}) ? ONE : {1'b0, cmd_row};
      ccol_x_s    = (cmd_col == {W{1'b0}}) ? ONE : {1'b0, cmd_col};
      inside_s    = (row_x_s >= top_x_s) && (row_x_s <= bot_x_s);
      lf_n_s      = (cmd_op == OP_PRINT) ? ONE : n_x_s;
      lf_sum_s    = row_x_s + lf_n_s;
      height_s    = bot_x_s - top_x_s + ONE;
      excess_s    = lf_sum_s - bot_x_s;
      lf_row_s    = lf_sum_s;
      lf_scroll_s = 1'b0;
      lf_step_s   = ZERO;
      if (inside_s) begin
         if (lf_sum_s > bot_x_s) begin
            lf_row_s    = bot_x_s;
            lf_scroll_s = 1'b1;
            lf_step_s   = (excess_s < height_s) ? excess_s : height_s;
         end else begin
            lf_row_s    = lf_sum_s;
         end
      end else begin
         lf_row_s = (lf_sum_s > LAST_ROW) ? LAST_ROW : lf_sum_s;
      end
   end

   // Next cursor state and scroll request for the command on the bus
   always_comb begin
      nrow_s    = row_x_s;
      ncol_s    = col_x_s;
      npw_s     = 1'b0;
      nscroll_s = 1'b0;
      ndir_s    = 1'b0;
      nstep_s   = ZERO;
      push_s    = 1'b0;
      pop_s     = 1'b0;
      base_s    = origin_mode ? top_x_s : ZERO;
      lim_s     = origin_mode ? bot_x_s : LAST_ROW;
      sum_s     = ZERO;
      lo_s      = ZERO;
      case (cmd_op)
         OP_CUP: begin
            sum_s  = base_s + crow_x_s - ONE;
            nrow_s = (sum_s > lim_s) ? lim_s : sum_s;
            ncol_s = ((ccol_x_s - ONE) > LAST_COL) ? LAST_COL : (ccol_x_s - ONE);
         end
         OP_CUF: begin
            sum_s  = col_x_s + n_x_s;
            ncol_s = (sum_s > LAST_COL) ? LAST_COL : sum_s;
         end
         OP_CUB: ncol_s = (col_x_s > n_x_s) ? (col_x_s - n_x_s) : ZERO;
         OP_CUD: begin
            lim_s  = inside_s ? bot_x_s : LAST_ROW;
            sum_s  = row_x_s + n_x_s;
            nrow_s = (sum_s > lim_s) ? lim_s : sum_s;
         end
         OP_CUU: begin
            lo_s   = inside_s ? top_x_s : ZERO;
            nrow_s = (row_x_s >= (lo_s + n_x_s)) ? (row_x_s - n_x_s) : lo_s;
         end
         OP_CR:  ncol_s = ZERO;
         OP_BS:  ncol_s = (col_x_s > ZERO) ? (col_x_s - ONE) : ZERO;
         OP_LF: begin
            nrow_s    = lf_row_s;
            nscroll_s = lf_scroll_s;
            nstep_s   = lf_step_s;
         end
         OP_PRINT: begin
            if (pw_r) begin
               if (auto_wrap) begin
                  ncol_s    = ONE;
                  nrow_s    = lf_row_s;
                  nscroll_s = lf_scroll_s;
                  nstep_s   = lf_step_s;
               end else begin
                  ncol_s    = col_x_s;
               end
            end else if (col_x_s < LAST_COL) begin
               ncol_s = col_x_s + ONE;
            end else begin
               npw_s  = 1'b1;
            end
         end
         OP_SAVE: begin
            push_s = 1'b1;
            npw_s  = pw_r;
         end
         OP_RESTORE: begin
            if (sp_r != {SPW{1'b0}}) begin
               pop_s  = 1'b1;
               sum_s  = {1'b0, top_entry_s[EW-1 -: W]};
               nrow_s = (sum_s > LAST_ROW) ? LAST_ROW : sum_s;
               lo_s   = {1'b0, top_entry_s[W:1]};
               ncol_s = (lo_s > LAST_COL) ? LAST_COL : lo_s;
               npw_s  = top_entry_s[0];
            end else begin
               nrow_s = base_s;
               ncol_s = ZERO;
            end
         end
         OP_RI: begin
            if (row_x_s == top_x_s) begin
               nscroll_s = 1'b1;
               ndir_s    = 1'b1;
               nstep_s   = ONE;
            end else begin
               nrow_s = (row_x_s > ZERO) ? (row_x_s - ONE) : ZERO;
            end
         end
         default: npw_s = 1'b0;
      endcase
   end

   // Command acceptance, cursor registers, stack pointer and scroll handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cur_row_r <= {W{1'b0}};
         cur_col_r <= {W{1'b0}};
         pw_r      <= 1'b0;
         sreq_r    <= 1'b0;
         sdir_r    <= 1'b0;
         sstep_r   <= {W{1'b0}};
         ready_r   <= 1'b1;
         ovf_r     <= 1'b0;
         sp_r      <= {SPW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  cur_row_r <= nrow_s[W-1:0];
                  cur_col_r <= ncol_s[W-1:0];
                  pw_r      <= npw_s;
                  sdir_r    <= ndir_s;
                  sstep_r   <= nstep_s[W-1:0];
                  if (push_s) begin
                     if (full_s) ovf_r <= 1'b1;
                     else        sp_r  <= sp_r + SPW'(1);
                  end
                  if (pop_s) sp_r <= sp_r - SPW'(1);
                  if (nscroll_s) begin
                     state_r <= SCROLL;
                     sreq_r  <= 1'b1;
                     ready_r <= 1'b0;
                  end
               end
            end
            SCROLL: begin
               if (scroll_ack) begin
                  state_r <= IDLE;
                  sreq_r  <= 1'b0;
                  ready_r <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               sreq_r  <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   // Save-stack storage; only the pointer needs reset
   always_ff @(posedge clk) begin
      if (!rst && accept_s && push_s) stack_r[push_idx_s] <= entry_s;
   end

endmodule

// File: tb/tb_cursor_engine.sv
// Directed scoreboard bench for cursor_engine: expected cursor/scroll state is
// queued with each step and compared when the DUT output is sampled.
module tb_cursor_engine;

   localparam int W = 8;
   localparam logic [3:0] NOP = 4'd0, CUP = 4'd1, CUF = 4'd2, CUB = 4'd3, CUD = 4'd4,
                          CUU = 4'd5, CR = 4'd6, LF = 4'd7, BS = 4'd8, PRT = 4'd9,
                          SAV = 4'd10, RST = 4'd11, RI = 4'd12, BAD = 4'd15;

   logic         clk = 1'b0;
   logic         rst, cmd_valid, cmd_ready, auto_wrap, origin_mode;
   logic [3:0]   cmd_op;
   logic [W-1:0] cmd_n, cmd_row, cmd_col, scroll_top, scroll_bottom;
   logic [W-1:0] cur_row, cur_col, scroll_step;
   logic         pending_wrap, scroll_req, scroll_dir, scroll_ack, save_overflow;

   always #5 clk = ~clk;

   cursor_engine #(.LINES(24), .COLUMNS(80), .W(W), .SAVE_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_n(cmd_n), .cmd_row(cmd_row), .cmd_col(cmd_col),
      .auto_wrap(auto_wrap), .origin_mode(origin_mode),
      .scroll_top(scroll_top), .scroll_bottom(scroll_bottom),
      .cur_row(cur_row), .cur_col(cur_col), .pending_wrap(pending_wrap),
      .scroll_req(scroll_req), .scroll_dir(scroll_dir), .scroll_step(scroll_step),
      .scroll_ack(scroll_ack), .save_overflow(save_overflow)
   );

   typedef struct {
      string tag;
      int    row;
      int    col;
      bit    pw;
      bit    sreq;
      bit    sdir;
      int    step;
      bit    ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) passes = passes + 1;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic expect_st(input string tag, input int r, input int c, input bit pw,
                            input bit sreq, input bit sdir, input int step, input bit ovf);
      exp_t e;
      e.tag = tag; e.row = r; e.col = c; e.pw = pw;
      e.sreq = sreq; e.sdir = sdir; e.step = step; e.ovf = ovf;
      sb.push_back(e);
   endtask

   task automatic check_st();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         fails++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".row"},   32'(cur_row),       32'(e.row));
         chk({e.tag, ".col"},   32'(cur_col),       32'(e.col));
         chk({e.tag, ".pw"},    32'(pending_wrap),  32'(e.pw));
         chk({e.tag, ".sreq"},  32'(scroll_req),    32'(e.sreq));
         chk({e.tag, ".ready"}, 32'(cmd_ready),     32'(!e.sreq));
         chk({e.tag, ".ovf"},   32'(save_overflow), 32'(e.ovf));
         if (e.sreq) begin
            chk({e.tag, ".dir"},  32'(scroll_dir),  32'(e.sdir));
            chk({e.tag, ".step"}, 32'(scroll_step), 32'(e.step));
         end
      end
   endtask

   task automatic do_cmd(input string tag, input logic [3:0] op, input int n, input int r,
                         input int c, input int er, input int ec, input bit epw,
                         input bit esreq, input bit edir, input int estep, input bit eovf);
      expect_st(tag, er, ec, epw, esreq, edir, estep, eovf);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_n     = W'(n);
      cmd_row   = W'(r);
      cmd_col   = W'(c);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check_st();
   endtask

   task automatic hold(input string tag, input int er, input int ec, input bit edir,
                       input int estep, input bit eovf);
      expect_st(tag, er, ec, 1'b0, 1'b1, edir, estep, eovf);
      @(posedge clk);
      #1;
      check_st();
   endtask

   task automatic do_ack(input string tag, input int er, input int ec, input bit eovf);
      expect_st(tag, er, ec, 1'b0, 1'b0, 1'b0, 0, eovf);
      @(negedge clk);
      scroll_ack = 1'b1;
      @(posedge clk);
      #1;
      scroll_ack = 1'b0;
      check_st();
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_n = '0; cmd_row = '0; cmd_col = '0;
      auto_wrap = 1'b1; origin_mode = 1'b0; scroll_top = 8'd0; scroll_bottom = 8'd23;
      scroll_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expect_st("reset", 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check_st();
      @(negedge clk);
      rst = 1'b0;

      // line feed past the bottom margin, commands ignored while scrolling
      do_cmd("cup_22_5", CUP, 1, 23, 6, 22, 5, 0, 0, 0, 0, 0);
      do_cmd("lf5", LF, 5, 0, 0, 23, 5, 0, 1, 0, 4, 0);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = CUP; cmd_row = 8'd1; cmd_col = 8'd1;
      hold("lf5_hold1", 23, 5, 0, 4, 0);
      hold("lf5_hold2", 23, 5, 0, 4, 0);
      cmd_valid = 1'b0;
      do_ack("lf5_ack", 23, 5, 0);

      // deferred wrap at the last column
      do_cmd("cup_23_78", CUP, 1, 24, 79, 23, 78, 0, 0, 0, 0, 0);
      do_cmd("print1", PRT, 1, 0, 0, 23, 79, 0, 0, 0, 0, 0);
      do_cmd("print2", PRT, 1, 0, 0, 23, 79, 1, 0, 0, 0, 0);
      do_cmd("print3", PRT, 1, 0, 0, 23, 1, 0, 1, 0, 1, 0);
      do_ack("print3_ack", 23, 1, 0);

      // horizontal and vertical moves with saturation
      do_cmd("cuf_n0", CUF, 0, 0, 0, 23, 2, 0, 0, 0, 0, 0);
      do_cmd("cub5", CUB, 5, 0, 0, 23, 0, 0, 0, 0, 0, 0);
      do_cmd("cuf200", CUF, 200, 0, 0, 23, 79, 0, 0, 0, 0, 0);
      do_cmd("bs", BS, 1, 0, 0, 23, 78, 0, 0, 0, 0, 0);
      do_cmd("cr", CR, 1, 0, 0, 23, 0, 0, 0, 0, 0, 0);
      do_cmd("cud3", CUD, 3, 0, 0, 23, 0, 0, 0, 0, 0, 0);
      do_cmd("cuu30", CUU, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // pending wrap without auto_wrap, and clearing by an unused opcode
      do_cmd("cup_0_79", CUP, 1, 1, 80, 0, 79, 0, 0, 0, 0, 0);
      do_cmd("pw_set", PRT, 1, 0, 0, 0, 79, 1, 0, 0, 0, 0);
      auto_wrap = 1'b0;
      do_cmd("pw_nowrap", PRT, 1, 0, 0, 0, 79, 0, 0, 0, 0, 0);
      auto_wrap = 1'b1;
      do_cmd("pw_set2", PRT, 1, 0, 0, 0, 79, 1, 0, 0, 0, 0);
      do_cmd("op15_clr", BAD, 1, 0, 0, 0, 79, 0, 0, 0, 0, 0);

      // origin mode inside margins 5..10
      origin_mode = 1'b1; scroll_top = 8'd5; scroll_bottom = 8'd10;
      do_cmd("cup_org", CUP, 1, 20, 100, 10, 79, 0, 0, 0, 0, 0);
      do_cmd("cuu9", CUU, 9, 0, 0, 5, 79, 0, 0, 0, 0, 0);
      do_cmd("lf20", LF, 20, 0, 0, 10, 79, 0, 1, 0, 6, 0);
      do_ack("lf20_ack", 10, 79, 0);

      // save stack overflow and restores
      do_cmd("s1_cup", CUP, 1, 1, 80, 5, 79, 0, 0, 0, 0, 0);
      do_cmd("s1_pw", PRT, 1, 0, 0, 5, 79, 1, 0, 0, 0, 0);
      do_cmd("save1", SAV, 1, 0, 0, 5, 79, 1, 0, 0, 0, 0);
      do_cmd("s2_cup", CUP, 1, 2, 2, 6, 1, 0, 0, 0, 0, 0);
      do_cmd("save2", SAV, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
      do_cmd("s3_cup", CUP, 1, 3, 3, 7, 2, 0, 0, 0, 0, 0);
      do_cmd("save3", SAV, 1, 0, 0, 7, 2, 0, 0, 0, 0, 0);
      do_cmd("s4_cup", CUP, 1, 4, 4, 8, 3, 0, 0, 0, 0, 0);
      do_cmd("save4", SAV, 1, 0, 0, 8, 3, 0, 0, 0, 0, 0);
      do_cmd("s5_cup", CUP, 1, 5, 5, 9, 4, 0, 0, 0, 0, 0);
      do_cmd("save5", SAV, 1, 0, 0, 9, 4, 0, 0, 0, 0, 1);
      do_cmd("rest1", RST, 1, 0, 0, 9, 4, 0, 0, 0, 0, 1);
      do_cmd("rest2", RST, 1, 0, 0, 7, 2, 0, 0, 0, 0, 1);
      do_cmd("rest3", RST, 1, 0, 0, 6, 1, 0, 0, 0, 0, 1);
      do_cmd("rest4", RST, 1, 0, 0, 5, 79, 1, 0, 0, 0, 1);
      do_cmd("rest5_home", RST, 1, 0, 0, 5, 0, 0, 0, 0, 0, 1);

      // reverse index at the top margin, then reset during the wait
      do_cmd("ri_top", RI, 1, 0, 0, 5, 0, 0, 1, 1, 1, 1);
      hold("ri_hold", 5, 0, 1, 1, 1);
      #2;
      rst = 1'b1;
      #1;
      expect_st("rst_mid", 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check_st();
      chk("rst_mid.dir", 32'(scroll_dir), 32'd0);
      chk("rst_mid.step", 32'(scroll_step), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      origin_mode = 1'b0;

      // moves outside the scroll region never scroll
      do_cmd("cup_3_0", CUP, 1, 4, 1, 3, 0, 0, 0, 0, 0, 0);
      do_cmd("ri_up", RI, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
      do_cmd("lf_out", LF, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      do_cmd("cud_out", CUD, 30, 0, 0, 23, 0, 0, 0, 0, 0, 0);
      do_cmd("ri_low", RI, 1, 0, 0, 22, 0, 0, 0, 0, 0, 0);
      do_cmd("rest_empty", RST, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
